// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, special register indices and word/index types
// for the MIPS register file.
package mips_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/mips_register_file_read_port.sv
// regfile_read_port: 32:1 read mux with $zero override; optional write-through
// bypass when MIPS_REGFILE_BYPASS_EN is defined.
module regfile_read_port import mips_pkg::*; #(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::ADDR_W,
   parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
   input  logic [DATA_W-1:0] i_regs [NUM_REGS],
   input  logic [ADDR_W-1:0] i_sel,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wa,
   input  logic [DATA_W-1:0] i_wd,
   output logic [DATA_W-1:0] o_data
);
   logic [DATA_W-1:0] w_raw;
   assign w_raw = (i_sel == ADDR_W'(REG_ZERO)) ? '0 : i_regs[i_sel];
`ifdef MIPS_REGFILE_BYPASS_EN
   // i_we is already qualified with a non-zero index and reset low
   assign o_data = (i_we && i_wa == i_sel) ? i_wd : w_raw;
`else
   logic w_unused;
   assign w_unused = &{1'b0, i_we, i_wa, i_wd};
   assign o_data = w_raw;
`endif
endmodule

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 register file, two combinational read ports, one
// sync write port, debug port, saturating write counter. Macro: MIPS_REGFILE_BYPASS_EN.
module mips_register_file import mips_pkg::*; #(
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int ADDR_W   = mips_pkg::ADDR_W,
   parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic [ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       write_count
);
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [15:0]       r_write_count;
   logic              w_we;
   // writes to $zero or during reset never commit and never bypass
   assign w_we = reg_write && !rst && write_reg != ADDR_W'(REG_ZERO);
   assign write_count = r_write_count;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_write_count <= '0;
      end else if (w_we) begin
         r_regs[write_reg] <= write_data;
         if (r_write_count != 16'hFFFF) r_write_count <= r_write_count + 16'd1;
      end
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rp1 (
      .i_regs(r_regs), .i_sel(read_reg1), .i_we(w_we), .i_wa(write_reg),
      .i_wd(write_data), .o_data(read_data1));
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rp2 (
      .i_regs(r_regs), .i_sel(read_reg2), .i_we(w_we), .i_wa(write_reg),
      .i_wd(write_data), .o_data(read_data2));
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rpd (
      .i_regs(r_regs), .i_sel(dbg_sel), .i_we(w_we), .i_wa(write_reg),
      .i_wd(write_data), .o_data(dbg_data));
endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit general-purpose register file of the single-cycle MIPS datapath.
- Sits directly downstream of the 5-bit destination-register mux: the mux output (rt or rd) drives write_reg here.
- Provides two combinational read ports for the ALU/branch stage and one synchronous write port for write-back.
- $zero is hardwired; a debug read port exposes any register to benches.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register index width
- NUM_REGS, 32, register count; must equal 2**ADDR_W

Ports:
- clk  input  1  system clock; all writes on the rising edge
- rst  input  1  asynchronous, active-high reset
- read_reg1  input  ADDR_W  index for read port 1 (instr[25:21], rs)
- read_reg2  input  ADDR_W  index for read port 2 (instr[20:16], rt)
- write_reg  input  ADDR_W  destination index from the destination-register mux
- write_data  input  DATA_W  write-back value (ALU result or memory load)
- reg_write  input  1  write enable from the control unit
- read_data1  output  DATA_W  contents of read_reg1
- read_data2  output  DATA_W  contents of read_reg2
- dbg_sel  input  ADDR_W  debug read index
- dbg_data  output  DATA_W  contents of dbg_sel, same rules as the read ports
- write_count  output  16  number of committed non-zero-index writes since reset; saturates at 16'hFFFF

Behaviour:
- Reset:
  - rst high clears all 32 registers to 0 and write_count to 0 immediately, without waiting for clk.
  - All read outputs are therefore 0 while rst is asserted.
  - A write presented during reset is dropped.
  - Deassertion is not synchronised internally; the first write is accepted at the first rising edge with rst low.
- Write:
  - At posedge clk with reg_write=1 and write_reg!=0, regs[write_reg] <= write_data and write_count increments by 1, holding at 16'hFFFF.
  - write_reg=0 writes are silently discarded and do not increment write_count.
  - reg_write=0 leaves all state unchanged.
- Read:
  - read_data1/2 and dbg_data are purely combinational from the register array; zero clock latency.
  - Index 0 always reads 32'h0000_0000 regardless of array contents.
  - Both read ports may address the same register; both return the same value.
- Same-cycle read/write of the same index: default behaviour (macro off) is that reads return the old value until the clock edge and the new value after it.
- X-safety: an unknown write_reg while reg_write=1 corrupts no register other than the addressed one. The bench flags this with an assertion rather than defining a result.
- Reset mid-operation: asserting rst in the same cycle as a write yields all-zero state; write_count stays 0.

Optional Feature:
- Macro: MIPS_REGFILE_BYPASS_EN.
- Defined:
  - When reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN returns write_data combinationally in the same cycle (write-through bypass). This covers a future pipelined write-back.
  - dbg_data bypasses identically.
- Undefined: no bypass; read ports show array contents only.
- Array update timing and write_count are identical in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS constants
  - REG_ZERO=5'd0 and REG_RA=5'd31 constants
  - typedefs reg_idx_t (ADDR_W bits) and word_t (DATA_W bits)
- One sub-module, regfile_read_port, instanced three times (port 1, port 2, debug). It contains the 32:1 read mux, the zero-index override and the optional bypass compare.

Test Plan:
- Reset: preload via writes, pulse rst for 7 time units mid-cycle -> all reads and dbg_data immediately 0, write_count=0, before any clock edge.
- Basic write/read: reg_write=1, write_reg=5'd8, write_data=32'hDEADBEEF, one clock -> read_reg1=8 gives 32'hDEADBEEF, write_count=1.
- Zero register: write_reg=0, write_data=32'hFFFFFFFF, clock -> read_data1 with read_reg1=0 is 32'h0; write_count unchanged.
- Destination-mux integration: drive write_reg from the destination mux with select=1, rd=5'd17, rt=5'd9, write 32'h0000_1234 -> reg 17 holds 32'h1234, reg 9 stays 0.
- Same-cycle read/write, reg 3 holds 32'h1111, writing 32'h2222:
  - Without MIPS_REGFILE_BYPASS_EN: read_data2 = 32'h1111 before the edge, 32'h2222 after.
  - With MIPS_REGFILE_BYPASS_EN: read_data2 = 32'h2222 before the edge.
- Counter saturation: force 65540 writes to reg 31 -> write_count = 16'hFFFF, reg 31 holds the last value written.
